blink_sequencer: RTL and testbench
==================================

Name: blink_sequencer

Overview:
- Controller that sequences the board LED through a programmed burst of N blinks, then reports completion.
- Built on a free-running prescaled counter: a prescaler derives a tick from the board clock, and an FSM counts on- and off-phases in ticks.
- Sits between top-level control logic (START/COUNT/phase lengths) and the LED pin (e.g. D5). Replaces the bare counter-MSB blink with a commandable, handshaked sequence.

Parameters:
- PRESCALE, 6000000, clock cycles per tick (>= 2); 2 Hz tick at 12 MHz CLKIN.
- PRE_W, 24, prescaler counter width; must satisfy 2**PRE_W >= PRESCALE.
- CNT_W, 4, width of the blink-count input.
- PH_W, 8, width of the on/off phase-length inputs, in ticks.

Ports:
- CLK  in  1  board clock; all state updates on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- START  in  1  request a burst; accepted only in IDLE.
- COUNT  in  CNT_W  number of blinks; sampled on accept.
- ON_TICKS  in  PH_W  LED-on phase length in ticks; sampled on accept.
- OFF_TICKS  in  PH_W  LED-off phase length in ticks; sampled on accept.
- LED  out  1  LED drive; 1 = lit.
- BUSY  out  1  high from the cycle after accept through the DONE cycle inclusive.
- DONE  out  1  single-cycle completion pulse.
- TICK  out  1  prescaler tick, for debug and observation.

Behaviour:
- Reset (async, RESET=1): state=IDLE, prescaler=0, phase_cnt=0, remaining=0. Outputs LED=0, BUSY=0, DONE=0, TICK=0. Any burst in progress is abandoned immediately, and no DONE is generated for it.
- Prescaler:
  - Runs from 0 to PRESCALE-1 and wraps to 0.
  - Loads 0 on the accept edge.
  - TICK = BUSY && prescaler==PRESCALE-1, combinational.
  - In IDLE the prescaler holds at 0 and TICK=0.
- Accept: a rising edge with state=IDLE and START=1.
  - Latches COUNT, ON_TICKS and OFF_TICKS into internal registers. Later input changes have no effect on the running burst.
  - Next state is ON if COUNT!=0, else FIN.
  - START is ignored in every state except IDLE; it is not queued.
- Phase-length rule: a latched ON_TICKS or OFF_TICKS value of 0 is treated as 1.
- States:
  - IDLE: LED=0, BUSY=0.
  - ON: LED=1. phase_cnt increments on each TICK. On the TICK where phase_cnt==on_len-1, go to OFF and clear phase_cnt.
  - OFF: LED=0. Same counting with off_len. On the terminating TICK:
    - if remaining==1, go to FIN;
    - otherwise decrement remaining and go to ON.
  - FIN: LED=0, DONE=1, BUSY=1 for exactly one cycle, then IDLE.
- Latency:
  - LED rises in the cycle after accept.
  - Each ON phase lasts exactly on_len*PRESCALE cycles; each OFF phase lasts off_len*PRESCALE cycles.
  - DONE is asserted in the cycle after the last OFF tick.
  - A new START may be accepted in the cycle after DONE (IDLE).
  - Total BUSY length = COUNT*(on_len+off_len)*PRESCALE + 1 cycles.
- COUNT=0: accept, then FIN (DONE) in the next cycle, then IDLE. LED never lights.
- Maximum count: COUNT=2**CNT_W-1 produces that many blinks, with no wrap of remaining.
- Phase counters are PH_W bits wide and never overflow, because they clear at the limit.

Decomposition:
- Shared package blink_pkg holds:
  - state enum {IDLE, ON, OFF, FIN}, 2-bit encoding;
  - default constants PRESCALE_DEFAULT=6000000, PRE_W_DEFAULT=24.
- Sub-module tick_prescaler: parameters PRESCALE and PRE_W; ports CLK, RESET, CLR, EN, TICK. The FSM, phase counter and remaining counter stay in blink_sequencer.

Test Plan (PRESCALE=4 for all benches; cycle 0 = accept edge):
- Basic burst: COUNT=2, ON=1, OFF=2. Required: LED=1 on cycles 1-4 and 13-16, 0 elsewhere; TICK on cycles 4,8,12,16,20,24; DONE only on cycle 25; BUSY on cycles 1-25; IDLE on cycle 26.
- Zero count: COUNT=0. Required: DONE=1 and BUSY=1 on cycle 1 only; LED stays 0.
- Zero phase lengths: COUNT=1, ON=0, OFF=0. Required: behaves as 1/1; LED on cycles 1-4; DONE on cycle 9.
- Ignored START and input stability: pulse START and change COUNT/ON/OFF during a COUNT=3, ON=1, OFF=1 burst. Required: exactly 3 blinks, one DONE on cycle 25, no second burst.
- Reset mid-burst: assert RESET on cycle 6 of the basic burst. Required: same cycle (async) LED=0, BUSY=0, TICK=0; no DONE; a START after release gives a fresh, correctly timed burst.
- Back-to-back: START held high continuously with COUNT=1, ON=1, OFF=1. Required: DONE on cycle 9, re-accept on the cycle 10 edge, LED rises on cycle 11.

Source files
------------

// File: rtl/blink_pkg.sv
// Shared types and default constants for the blink sequencer slice.
// Contents: the sequencer state enum and the default prescaler, count and
// phase widths used as parameter defaults by the interface and modules.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2,
        FIN  = 2'd3
    } state_t;

    localparam int unsigned PRESCALE_DEFAULT = 6000000;
    localparam int unsigned PRE_W_DEFAULT    = 24;
    localparam int unsigned CNT_W_DEFAULT    = 4;
    localparam int unsigned PH_W_DEFAULT     = 8;

endpackage

// File: rtl/blink_sequencer_if.sv
// Command/status bundle between top-level control logic and the sequencer.
// master: drives START, COUNT, ON_TICKS, OFF_TICKS; observes LED, BUSY, DONE, TICK.
// slave : the sequencer side of the same signals.
interface blink_sequencer_if
    import blink_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT,
    parameter int unsigned PH_W  = PH_W_DEFAULT
) ();

    logic             START;
    logic [CNT_W-1:0] COUNT;
    logic [PH_W-1:0]  ON_TICKS;
    logic [PH_W-1:0]  OFF_TICKS;
    logic             LED;
    logic             BUSY;
    logic             DONE;
    logic             TICK;

    modport master (
        output START, COUNT, ON_TICKS, OFF_TICKS,
        input  LED, BUSY, DONE, TICK
    );

    modport slave (
        input  START, COUNT, ON_TICKS, OFF_TICKS,
        output LED, BUSY, DONE, TICK
    );

endinterface

// File: rtl/tick_prescaler.sv
// Free-running prescaler producing one TICK every PRESCALE enabled cycles.
// Ports: CLK (clock), RESET (async, active-high), CLR (sync load of 0, wins
// over EN), EN (count enable), TICK (combinational, EN && count at terminal).
module tick_prescaler
    import blink_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT,
    parameter int unsigned PRE_W    = PRE_W_DEFAULT
) (
    input  logic CLK,
    input  logic RESET,
    input  logic CLR,
    input  logic EN,
    output logic TICK
);

    localparam logic [PRE_W-1:0] LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] count;

    // Counts 0..PRESCALE-1 and wraps; held at 0 while cleared.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            count <= '0;
        end else if (CLR) begin
            count <= '0;
        end else if (EN) begin
            if (count == LAST) begin
                count <= '0;
            end else begin
                count <= count + PRE_W'(1);
            end
        end
    end

    assign TICK = EN && (count == LAST);

endmodule

// File: rtl/blink_sequencer.sv
// Sequences the LED through a burst of COUNT blinks (ON_TICKS lit, OFF_TICKS
// dark, in prescaler ticks) and pulses DONE when the burst completes.
// Ports: CLK, RESET (async, active-high), bus (slave side: START, COUNT,
// ON_TICKS, OFF_TICKS in; LED, BUSY, DONE registered out; TICK comb out).
module blink_sequencer
    import blink_pkg::*;
#(
    parameter int unsigned PRESCALE = PRESCALE_DEFAULT,
    parameter int unsigned PRE_W    = PRE_W_DEFAULT,
    parameter int unsigned CNT_W    = CNT_W_DEFAULT,
    parameter int unsigned PH_W     = PH_W_DEFAULT
) (
    input  logic                 CLK,
    input  logic                 RESET,
    blink_sequencer_if.slave     bus
);

    state_t           state;
    logic [CNT_W-1:0] remaining;
    logic [PH_W-1:0]  phase_cnt;
    logic [PH_W-1:0]  on_len;
    logic [PH_W-1:0]  off_len;
    logic [PH_W-1:0]  phase_last;
    logic             led_q;
    logic             busy_q;
    logic             done_q;
    logic             tick;
    logic             presc_clr;
    logic             presc_en;

    // Prescaler is parked at 0 in IDLE, which also covers the load on accept.
    assign presc_clr = (state == IDLE);
    assign presc_en  = (state == ON) || (state == OFF);

    tick_prescaler #(
        .PRESCALE (PRESCALE),
        .PRE_W    (PRE_W)
    ) u_prescaler (
        .CLK   (CLK),
        .RESET (RESET),
        .CLR   (presc_clr),
        .EN    (presc_en),
        .TICK  (tick)
    );

    // Terminal phase count for whichever phase is running.
    assign phase_last = ((state == ON) ? on_len : off_len) - PH_W'(1);

    // Burst FSM with registered LED/BUSY/DONE.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= IDLE;
            remaining <= '0;
            phase_cnt <= '0;
            on_len    <= PH_W'(1);
            off_len   <= PH_W'(1);
            led_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.START) begin
                        remaining <= bus.COUNT;
                        // A zero phase length is stretched to one tick.
                        on_len    <= (bus.ON_TICKS  == '0) ? PH_W'(1) : bus.ON_TICKS;
                        off_len   <= (bus.OFF_TICKS == '0) ? PH_W'(1) : bus.OFF_TICKS;
                        phase_cnt <= '0;
                        busy_q    <= 1'b1;
                        if (bus.COUNT != '0) begin
                            state <= ON;
                            led_q <= 1'b1;
                        end else begin
                            state  <= FIN;
                            done_q <= 1'b1;
                        end
                    end
                end
                ON: begin
                    if (tick) begin
                        if (phase_cnt == phase_last) begin
                            phase_cnt <= '0;
                            state     <= OFF;
                            led_q     <= 1'b0;
                        end else begin
                            phase_cnt <= phase_cnt + PH_W'(1);
                        end
                    end
                end
                OFF: begin
                    if (tick) begin
                        if (phase_cnt == phase_last) begin
                            phase_cnt <= '0;
                            if (remaining == CNT_W'(1)) begin
                                state  <= FIN;
                                done_q <= 1'b1;
                            end else begin
                                remaining <= remaining - CNT_W'(1);
                                state     <= ON;
                                led_q     <= 1'b1;
                            end
                        end else begin
                            phase_cnt <= phase_cnt + PH_W'(1);
                        end
                    end
                end
                FIN: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.LED  = led_q;
    assign bus.BUSY = busy_q;
    assign bus.DONE = done_q;
    assign bus.TICK = tick;

endmodule

// File: tb/tb_blink_sequencer.sv
// Self-checking bench for blink_sequencer with PRESCALE=4. A cycle-level
// model derives LED/BUSY/DONE/TICK from the burst parameters by arithmetic on
// the cycle number since accept; directed tests add literal spot checks.
module tb_blink_sequencer;

    localparam int unsigned P     = 4;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned PH_W  = 8;

    logic CLK   = 1'b0;
    logic RESET = 1'b0;

    int n_compared = 0;
    int n_mismatch = 0;

    blink_sequencer_if #(.CNT_W(CNT_W), .PH_W(PH_W)) bus ();

    blink_sequencer #(
        .PRESCALE (P),
        .PRE_W    (3),
        .CNT_W    (CNT_W),
        .PH_W     (PH_W)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial forever #5 CLK = ~CLK;

    // Model: active burst, cycle number since accept (1 = first busy cycle)
    // and the latched burst parameters.
    logic m_active = 1'b0;
    int   m_rel    = 0;
    int   m_on     = 1;
    int   m_off    = 1;
    int   m_total  = 0;

    function automatic int plen(input int v);
        return (v == 0) ? 1 : v;
    endfunction

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            m_active <= 1'b0;
            m_rel    <= 0;
        end else if (!m_active) begin
            if (bus.START) begin
                m_active <= 1'b1;
                m_rel    <= 1;
                m_on     <= plen(int'(bus.ON_TICKS));
                m_off    <= plen(int'(bus.OFF_TICKS));
                m_total  <= int'(bus.COUNT) *
                            (plen(int'(bus.ON_TICKS)) + plen(int'(bus.OFF_TICKS))) * int'(P);
            end
        end else if (m_rel >= m_total + 1) begin
            m_active <= 1'b0;
            m_rel    <= 0;
        end else begin
            m_rel <= m_rel + 1;
        end
    end

    task automatic check(input string name, input logic got, input logic exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got %0b required %0b at t=%0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model.
    always @(negedge CLK) begin
        logic e_led, e_busy, e_done, e_tick;
        e_busy = m_active;
        e_done = m_active && (m_rel == m_total + 1);
        e_led  = m_active && (m_rel <= m_total) &&
                 (((m_rel - 1) % ((m_on + m_off) * int'(P))) < m_on * int'(P));
        e_tick = m_active && (m_rel <= m_total) && ((m_rel % int'(P)) == 0);
        check("model_led",  bus.LED,  e_led);
        check("model_busy", bus.BUSY, e_busy);
        check("model_done", bus.DONE, e_done);
        check("model_tick", bus.TICK, e_tick);
    end

    // Drive a one-cycle START; returns at the negedge of cycle 1.
    task automatic launch(input int c, input int on, input int off);
        bus.START     = 1'b1;
        bus.COUNT     = 4'(c);
        bus.ON_TICKS  = 8'(on);
        bus.OFF_TICKS = 8'(off);
        @(posedge CLK);
        @(negedge CLK);
        bus.START = 1'b0;
    endtask

    task automatic goto_cyc(inout int cur, input int j);
        repeat (j - cur) @(negedge CLK);
        cur = j;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required finish");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch + 1);
        $fatal(1);
    end

    initial begin
        int cur;
        bus.START     = 1'b0;
        bus.COUNT     = '0;
        bus.ON_TICKS  = '0;
        bus.OFF_TICKS = '0;
        #1 RESET = 1'b1;
        @(negedge CLK);
        check("rst_led",  bus.LED,  1'b0);
        check("rst_busy", bus.BUSY, 1'b0);
        check("rst_done", bus.DONE, 1'b0);
        check("rst_tick", bus.TICK, 1'b0);
        repeat (2) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);

        // Basic burst: COUNT=2, ON=1, OFF=2.
        launch(2, 1, 2); cur = 1;
        check("basic_led_c1", bus.LED, 1'b1);
        goto_cyc(cur, 4);  check("basic_led_c4", bus.LED, 1'b1);
                           check("basic_tick_c4", bus.TICK, 1'b1);
        goto_cyc(cur, 5);  check("basic_led_c5", bus.LED, 1'b0);
        goto_cyc(cur, 13); check("basic_led_c13", bus.LED, 1'b1);
        goto_cyc(cur, 17); check("basic_led_c17", bus.LED, 1'b0);
        goto_cyc(cur, 24); check("basic_tick_c24", bus.TICK, 1'b1);
        goto_cyc(cur, 25); check("basic_done_c25", bus.DONE, 1'b1);
                           check("basic_busy_c25", bus.BUSY, 1'b1);
        goto_cyc(cur, 26); check("basic_busy_c26", bus.BUSY, 1'b0);
                           check("basic_done_c26", bus.DONE, 1'b0);
        goto_cyc(cur, 28);

        // Zero count: DONE in the cycle after accept, LED dark.
        launch(0, 5, 5); cur = 1;
        check("zero_done_c1", bus.DONE, 1'b1);
        check("zero_busy_c1", bus.BUSY, 1'b1);
        check("zero_led_c1",  bus.LED,  1'b0);
        goto_cyc(cur, 2);  check("zero_busy_c2", bus.BUSY, 1'b0);
        goto_cyc(cur, 4);

        // Zero phase lengths behave as 1/1.
        launch(1, 0, 0); cur = 1;
        goto_cyc(cur, 4);  check("zph_led_c4", bus.LED, 1'b1);
        goto_cyc(cur, 5);  check("zph_led_c5", bus.LED, 1'b0);
        goto_cyc(cur, 9);  check("zph_done_c9", bus.DONE, 1'b1);
        goto_cyc(cur, 10); check("zph_busy_c10", bus.BUSY, 1'b0);
        goto_cyc(cur, 12);

        // START pulses and input changes during a burst are ignored.
        launch(3, 1, 1); cur = 1;
        goto_cyc(cur, 3);
        bus.START = 1'b1; bus.COUNT = 4'd7; bus.ON_TICKS = 8'd5; bus.OFF_TICKS = 8'd9;
        goto_cyc(cur, 4);  bus.START = 1'b0;
        goto_cyc(cur, 10); bus.COUNT = 4'd0; bus.ON_TICKS = 8'd0;
        goto_cyc(cur, 12); bus.START = 1'b1;
        goto_cyc(cur, 13); bus.START = 1'b0;
        goto_cyc(cur, 17); check("ign_led_c17", bus.LED, 1'b1);
        goto_cyc(cur, 25); check("ign_done_c25", bus.DONE, 1'b1);
        goto_cyc(cur, 30); check("ign_busy_c30", bus.BUSY, 1'b0);
                           check("ign_led_c30", bus.LED, 1'b0);

        // Reset in the middle of a burst, then a fresh burst.
        launch(2, 1, 2); cur = 1;
        goto_cyc(cur, 6);
        #1 RESET = 1'b1;
        #1;
        check("mid_rst_led",  bus.LED,  1'b0);
        check("mid_rst_busy", bus.BUSY, 1'b0);
        check("mid_rst_tick", bus.TICK, 1'b0);
        check("mid_rst_done", bus.DONE, 1'b0);
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        launch(2, 1, 2); cur = 1;
        goto_cyc(cur, 4);  check("post_rst_tick_c4", bus.TICK, 1'b1);
        goto_cyc(cur, 25); check("post_rst_done_c25", bus.DONE, 1'b1);
        goto_cyc(cur, 27);

        // Maximum count: 15 blinks of 1/1.
        launch(15, 1, 1); cur = 1;
        goto_cyc(cur, 113); check("max_led_c113", bus.LED, 1'b1);
        goto_cyc(cur, 121); check("max_done_c121", bus.DONE, 1'b1);
        goto_cyc(cur, 122); check("max_busy_c122", bus.BUSY, 1'b0);

        // Back-to-back with START held high.
        bus.START = 1'b1; bus.COUNT = 4'd1; bus.ON_TICKS = 8'd1; bus.OFF_TICKS = 8'd1;
        @(posedge CLK);
        @(negedge CLK); cur = 1;
        goto_cyc(cur, 9);  check("b2b_done_c9", bus.DONE, 1'b1);
        goto_cyc(cur, 10); check("b2b_busy_c10", bus.BUSY, 1'b0);
                           check("b2b_led_c10", bus.LED, 1'b0);
        goto_cyc(cur, 11); check("b2b_led_c11", bus.LED, 1'b1);
                           bus.START = 1'b0;
        goto_cyc(cur, 19); check("b2b_done_c19", bus.DONE, 1'b1);
        goto_cyc(cur, 23); check("b2b_busy_c23", bus.BUSY, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
